qcw_burst_sequencer: RTL and testbench

//  Sequences qcw_pll bursts for the QCW driver: accepts a trigger, launches the PLL with a cycle limit, ramps phase_shift

---
 rtl/qcw_pkg.sv | 17 +
 rtl/qcw_phase_ramp.sv | 48 ++++
 rtl/qcw_burst_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_qcw_burst_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcw_pkg.sv
// Shared types and constants for the QCW burst sequencer.
package qcw_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_GUARD    = 3'd2,
    S_RUN      = 3'd3,
    S_COOLDOWN = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam int unsigned PHASE_W    = 8;
  localparam int unsigned PHASE_FRAC = 4;
  localparam int unsigned ACC_W      = PHASE_W + PHASE_FRAC;

endpackage

// File: rtl/qcw_phase_ramp.sv
// Q8.4 saturating phase accumulator: load a start value, add a Q4.4 step
// per drive cycle, clamp at the ramp ceiling. Output is the integer part.
module qcw_phase_ramp
  import qcw_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_load_val,
  input  logic               i_step_en,
  input  logic [PHASE_W-1:0] i_step,
  input  logic [PHASE_W-1:0] i_end,
  output logic [PHASE_W-1:0] o_phase
);

  localparam int unsigned EXT_W = ACC_W + 1 - PHASE_W;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_ceil;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_next;

  assign w_ceil = {i_end, {PHASE_FRAC{1'b0}}};
  assign w_sum  = {1'b0, r_acc} + {{EXT_W{1'b0}}, i_step};

  // min(acc + step, ceiling); one extra sum bit so the add never wraps.
  // An accumulator already above the ceiling (end < start) clamps down too.
  always_comb begin
    w_next = w_sum[ACC_W-1:0];
    if (w_sum > {1'b0, w_ceil}) begin
      w_next = w_ceil;
    end
  end

  // Accumulator register: load has priority over stepping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= {i_load_val, {PHASE_FRAC{1'b0}}};
    end else if (i_step_en) begin
      r_acc <= w_next;
    end
  end

  assign o_phase = r_acc[ACC_W-1:PHASE_FRAC];

endmodule

// File: rtl/qcw_burst_sequencer.sv
// QCW burst sequencer: trigger -> ARM (start pulse) -> GUARD -> RUN (phase
// ramp, watchdog) -> COOLDOWN -> IDLE, with a latched FAULT state.
// Optional feature macro: QCW_AUTO_RETRY_EN (auto re-arm after PLL fault).
module qcw_burst_sequencer
  import qcw_pkg::*;
#(
  parameter int unsigned COOLDOWN_W  = 16,
  parameter int unsigned WDOG_CYCLES = 2000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_trigger,
  input  logic                  i_abort,
  input  logic [15:0]           i_cfg_cycles,
  input  logic [7:0]            i_cfg_phase_start,
  input  logic [7:0]            i_cfg_phase_end,
  input  logic [7:0]            i_cfg_ramp_step,
  input  logic [COOLDOWN_W-1:0] i_cfg_cooldown,
  input  logic                  i_clear_fault,
  input  logic                  i_pll_cycle_finished,
  input  logic                  i_pll_done,
  input  logic                  i_pll_fault,
  output logic                  o_pll_start,
  output logic                  o_pll_halt,
  output logic [7:0]            o_pll_phase_shift,
  output logic [15:0]           o_pll_cycle_limit,
  output logic                  o_busy,
  output logic                  o_fault_lock,
  output logic                  o_missed_trigger,
  output logic [15:0]           o_burst_count
);

`ifdef QCW_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int unsigned WDOG_W  = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  state_t r_state;
  state_t w_state_nxt;

  logic r_trig_q, r_done_q, r_fault_q;
  logic w_trig_ev, w_done_ev, w_fault_ev;

  logic [15:0]           r_cycles;
  logic [7:0]            r_phase_start;
  logic [7:0]            r_phase_end;
  logic [7:0]            r_step;
  logic [COOLDOWN_W-1:0] r_cool;
  logic [WDOG_W-1:0]     r_wdog;
  logic                  r_guard_cnt;
  logic [RETRY_W-1:0]    r_retries;
  logic                  r_retry_pend;
  logic                  r_missed;
  logic [15:0]           r_burst_cnt;

  logic       w_accept;
  logic       w_wdog_trip;
  logic       w_retry_ok;
  logic       w_ramp_load;
  logic [7:0] w_ramp_load_val;
  logic       w_ramp_step;
  logic       w_cool_load;
  logic       w_count_burst;
  logic       w_retry_inc;
  logic       w_retry_clr;
  logic       w_pll_start;
  logic       w_pll_halt;
  logic [7:0] w_phase;

  assign w_trig_ev  = i_trigger & ~r_trig_q;
  assign w_done_ev  = i_pll_done & ~r_done_q;
  assign w_fault_ev = i_pll_fault & ~r_fault_q;

  assign w_accept    = (r_state == S_IDLE) && w_trig_ev && i_enable && (i_cfg_cycles != '0);
  assign w_wdog_trip = (r_state == S_RUN) && (r_wdog == WDOG_W'(WDOG_CYCLES));
  assign w_retry_ok  = RETRY_EN && (r_retries < RETRY_W'(MAX_RETRIES));
  assign w_ramp_step = (r_state == S_RUN) && i_pll_cycle_finished;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state control strobes.
  // In RUN a fault edge outranks the watchdog, which outranks a done edge,
  // so a simultaneous done/fault never counts the burst.
  always_comb begin
    w_state_nxt     = r_state;
    w_ramp_load     = 1'b0;
    w_ramp_load_val = r_phase_start;
    w_cool_load     = 1'b0;
    w_count_burst   = 1'b0;
    w_retry_inc     = 1'b0;
    w_retry_clr     = 1'b0;
    w_pll_start     = 1'b0;
    w_pll_halt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ramp_load     = 1'b1;
          w_ramp_load_val = i_cfg_phase_start;
          w_retry_clr     = 1'b1;
          w_state_nxt     = S_ARM;
        end
      end
      S_ARM: begin
        w_pll_start = 1'b1;
        w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (r_guard_cnt) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_pll_halt = 1'b1;
        end
        if (w_fault_ev) begin
          if (w_retry_ok) begin
            w_retry_inc = 1'b1;
            w_cool_load = 1'b1;
            w_state_nxt = S_COOLDOWN;
          end else begin
            w_state_nxt = S_FAULT;
          end
        end else if (w_wdog_trip) begin
          w_pll_halt  = 1'b1;
          w_state_nxt = S_FAULT;
        end else if (w_done_ev) begin
          w_count_burst = 1'b1;
          w_cool_load   = 1'b1;
          w_retry_clr   = 1'b1;
          w_state_nxt   = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (r_cool == '0) begin
          if (r_retry_pend) begin
            w_ramp_load = 1'b1;
            w_state_nxt = S_ARM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        w_pll_halt = 1'b1;
        if (i_clear_fault) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Edge detectors, latched config, counters and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_trig_q      <= 1'b0;
      r_done_q      <= 1'b0;
      r_fault_q     <= 1'b0;
      r_cycles      <= '0;
      r_phase_start <= '0;
      r_phase_end   <= '0;
      r_step        <= '0;
      r_cool        <= '0;
      r_wdog        <= '0;
      r_guard_cnt   <= 1'b0;
      r_retries     <= '0;
      r_retry_pend  <= 1'b0;
      r_missed      <= 1'b0;
      r_burst_cnt   <= '0;
    end else begin
      r_trig_q  <= i_trigger;
      r_done_q  <= i_pll_done;
      r_fault_q <= i_pll_fault;

      if (w_accept) begin
        r_cycles      <= i_cfg_cycles;
        r_phase_start <= i_cfg_phase_start;
        r_phase_end   <= i_cfg_phase_end;
        r_step        <= i_cfg_ramp_step;
      end

      r_guard_cnt <= (r_state == S_GUARD) ? ~r_guard_cnt : 1'b0;

      if ((r_state == S_RUN) && !i_pll_cycle_finished) begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end else begin
        r_wdog <= '0;
      end

      if (w_cool_load) begin
        r_cool <= i_cfg_cooldown;
      end else if ((r_state == S_COOLDOWN) && (r_cool != '0)) begin
        r_cool <= r_cool - COOLDOWN_W'(1);
      end

      if (w_retry_clr) begin
        r_retries <= '0;
      end else if (w_retry_inc) begin
        r_retries <= r_retries + RETRY_W'(1);
      end

      if (w_retry_inc) begin
        r_retry_pend <= 1'b1;
      end else if (w_ramp_load || w_retry_clr) begin
        r_retry_pend <= 1'b0;
      end

      if (i_clear_fault) begin
        r_missed <= 1'b0;
      end else if (w_trig_ev && !w_accept) begin
        r_missed <= 1'b1;
      end

      if (w_count_burst) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
    end
  end

  qcw_phase_ramp u_ramp (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_ramp_load),
    .i_load_val (w_ramp_load_val),
    .i_step_en  (w_ramp_step),
    .i_step     (r_step),
    .i_end      (r_phase_end),
    .o_phase    (w_phase)
  );

  assign o_pll_start       = w_pll_start;
  assign o_pll_halt        = w_pll_halt;
  assign o_pll_phase_shift = ((r_state == S_ARM) || (r_state == S_GUARD) || (r_state == S_RUN))
                             ? w_phase : '0;
  assign o_pll_cycle_limit = r_cycles;
  assign o_busy            = (r_state != S_IDLE);
  assign o_fault_lock      = (r_state == S_FAULT);
  assign o_missed_trigger  = r_missed;
  assign o_burst_count     = r_burst_cnt;

endmodule

// File: tb/tb_qcw_burst_sequencer.sv
// Directed self-checking bench for qcw_burst_sequencer.
module tb_qcw_burst_sequencer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        trigger;
  logic        abort;
  logic [15:0] cfg_cycles;
  logic [7:0]  cfg_phase_start;
  logic [7:0]  cfg_phase_end;
  logic [7:0]  cfg_ramp_step;
  logic [15:0] cfg_cooldown;
  logic        clear_fault;
  logic        pll_cycle_finished;
  logic        pll_done;
  logic        pll_fault;
  logic        pll_start;
  logic        pll_halt;
  logic [7:0]  pll_phase_shift;
  logic [15:0] pll_cycle_limit;
  logic        busy;
  logic        fault_lock;
  logic        missed_trigger;
  logic [15:0] burst_count;

  int n_checks = 0;
  int n_err    = 0;
  int n_start  = 0;

  qcw_burst_sequencer #(
    .COOLDOWN_W  (16),
    .WDOG_CYCLES (2000),
    .MAX_RETRIES (3)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_enable             (enable),
    .i_trigger            (trigger),
    .i_abort              (abort),
    .i_cfg_cycles         (cfg_cycles),
    .i_cfg_phase_start    (cfg_phase_start),
    .i_cfg_phase_end      (cfg_phase_end),
    .i_cfg_ramp_step      (cfg_ramp_step),
    .i_cfg_cooldown       (cfg_cooldown),
    .i_clear_fault        (clear_fault),
    .i_pll_cycle_finished (pll_cycle_finished),
    .i_pll_done           (pll_done),
    .i_pll_fault          (pll_fault),
    .o_pll_start          (pll_start),
    .o_pll_halt           (pll_halt),
    .o_pll_phase_shift    (pll_phase_shift),
    .o_pll_cycle_limit    (pll_cycle_limit),
    .o_busy               (busy),
    .o_fault_lock         (fault_lock),
    .o_missed_trigger     (missed_trigger),
    .o_burst_count        (burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pll_start) n_start++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic fire();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int s0;
    rst = 1'b1; enable = 1'b1; trigger = 1'b0; abort = 1'b0;
    cfg_cycles = 16'd10; cfg_phase_start = 8'h20; cfg_phase_end = 8'h80;
    cfg_ramp_step = 8'h10; cfg_cooldown = 16'd5; clear_fault = 1'b0;
    pll_cycle_finished = 1'b0; pll_done = 1'b0; pll_fault = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, pll_start}, 32'd0);
    check("rst_halt",  {31'd0, pll_halt}, 32'd0);
    check("rst_phase", {24'd0, pll_phase_shift}, 32'd0);
    check("rst_limit", {16'd0, pll_cycle_limit}, 32'd0);
    check("rst_count", {16'd0, burst_count}, 32'd0);
    check("rst_missed", {31'd0, missed_trigger}, 32'd0);
    rst = 1'b0;
    tick();

    // Linear ramp: start 0x20, step 1.0, ten cycles
    s0 = n_start;
    fire();
    check("arm_start", {31'd0, pll_start}, 32'd1);
    check("arm_limit", {16'd0, pll_cycle_limit}, 32'd10);
    check("arm_phase", {24'd0, pll_phase_shift}, 32'h20);
    tick();
    check("guard_start", {31'd0, pll_start}, 32'd0);
    tick(); tick();
    for (int i = 1; i <= 10; i++) begin
      pll_cycle_finished = 1'b1;
      tick();
      pll_cycle_finished = 1'b0;
      check($sformatf("ramp_%0d", i), {24'd0, pll_phase_shift}, 32'h20 + i);
      tick();
    end
    pll_done = 1'b1;
    tick();
    check("done_count", {16'd0, burst_count}, 32'd1);
    check("cool_busy", {31'd0, busy}, 32'd1);
    check("cool_phase", {24'd0, pll_phase_shift}, 32'd0);
    pll_done = 1'b0;
    wait_idle(100, n);
    check("one_start_pulse", n_start - s0, 32'd1);

    // Saturation: 0x38 + 15.94 > 0x40 ceiling, cooldown 0
    cfg_cycles = 16'd5; cfg_phase_start = 8'h38; cfg_phase_end = 8'h40;
    cfg_ramp_step = 8'hFF; cfg_cooldown = 16'd0;
    fire(); tick(); tick(); tick();
    check("sat_limit", {16'd0, pll_cycle_limit}, 32'd5);
    for (int i = 0; i < 3; i++) begin
      pll_cycle_finished = 1'b1;
      tick();
      pll_cycle_finished = 1'b0;
      check($sformatf("sat_%0d", i), {24'd0, pll_phase_shift}, 32'h40);
    end
    pll_done = 1'b1;
    tick();
    check("cd0_busy", {31'd0, busy}, 32'd1);
    tick();
    check("cd0_idle", {31'd0, busy}, 32'd0);
    pll_done = 1'b0;
    check("sat_count", {16'd0, burst_count}, 32'd2);

    // Ramp down: end < start clamps on the first cycle; then cooldown 50
    cfg_cycles = 16'd3; cfg_phase_start = 8'h50; cfg_phase_end = 8'h30;
    cfg_ramp_step = 8'h01; cfg_cooldown = 16'd50;
    fire(); tick(); tick(); tick();
    pll_cycle_finished = 1'b1;
    tick();
    pll_cycle_finished = 1'b0;
    check("rampdown", {24'd0, pll_phase_shift}, 32'h30);
    pll_done = 1'b1;
    tick();
    pll_done = 1'b0;
    s0 = n_start;
    for (int i = 0; i < 9; i++) tick();
    fire();
    check("cool_no_start", {31'd0, pll_start}, 32'd0);
    check("cool_missed", {31'd0, missed_trigger}, 32'd1);
    wait_idle(200, n);
    check("cool_len", n, 32'd41);
    check("cool_no_pulse", n_start - s0, 32'd0);

    // Accepted after cooldown, then abort and PLL fault
    cfg_cycles = 16'd8; cfg_phase_start = 8'h10; cfg_phase_end = 8'h80;
    cfg_ramp_step = 8'h10;
    fire();
    check("post_cool_start", {31'd0, pll_start}, 32'd1);
    tick(); tick(); tick();
    pll_cycle_finished = 1'b1;
    tick();
    pll_cycle_finished = 1'b0;
    check("run_phase", {24'd0, pll_phase_shift}, 32'h11);
    abort = 1'b1; #1;
    check("abort_halt", {31'd0, pll_halt}, 32'd1);
    abort = 1'b0; #1;
    check("abort_release", {31'd0, pll_halt}, 32'd0);
    pll_fault = 1'b1;
    pll_done = 1'b1;
    tick();
    check("fault_lock", {31'd0, fault_lock}, 32'd1);
    check("fault_halt", {31'd0, pll_halt}, 32'd1);
    check("fault_phase", {24'd0, pll_phase_shift}, 32'd0);
    check("fault_no_count", {16'd0, burst_count}, 32'd3);
    pll_fault = 1'b0; pll_done = 1'b0;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_lock", {31'd0, fault_lock}, 32'd0);
    check("clr_missed", {31'd0, missed_trigger}, 32'd0);
    check("clr_halt", {31'd0, pll_halt}, 32'd0);

    // Refusals: zero cycles, then enable low
    s0 = n_start;
    cfg_cycles = 16'd0;
    fire();
    check("zero_cyc_busy", {31'd0, busy}, 32'd0);
    check("zero_cyc_missed", {31'd0, missed_trigger}, 32'd1);
    cfg_cycles = 16'd4; enable = 1'b0;
    tick();
    fire();
    check("disabled_busy", {31'd0, busy}, 32'd0);
    tick();
    check("refused_no_pulse", n_start - s0, 32'd0);
    enable = 1'b1;

    // Watchdog: no cycle_finished for WDOG_CYCLES clocks
    fire(); tick(); tick(); tick();
    pll_cycle_finished = 1'b1;
    tick();
    pll_cycle_finished = 1'b0;
    n = 0;
    while (!fault_lock && n < 2100) begin
      tick();
      n++;
    end
    check("wdog_clks", n, 32'd2001);
    check("wdog_halt", {31'd0, pll_halt}, 32'd1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;

    // Reset mid-burst drops outputs
    cfg_cooldown = 16'd2;
    fire();
    check("pre_rst_start", {31'd0, pll_start}, 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_start", {31'd0, pll_start}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_limit", {16'd0, pll_cycle_limit}, 32'd0);
    check("midrst_count", {16'd0, burst_count}, 32'd0);
    rst = 1'b0;
    tick();

`ifdef QCW_AUTO_RETRY_EN
    // Four consecutive faults: three automatic re-arms, fourth locks
    s0 = n_start;
    fire();
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        n = 0;
        while (!pll_start && n < 20) begin
          tick();
          n++;
        end
        check($sformatf("rearm_%0d", f), {31'd0, pll_start}, 32'd1);
      end
      tick(); tick(); tick();
      pll_fault = 1'b1;
      tick();
      pll_fault = 1'b0;
    end
    check("retry_lock", {31'd0, fault_lock}, 32'd1);
    check("retry_starts", n_start - s0, 32'd4);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
